// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, complex sample type and framer state encoding
// for the 8-point FFT datapath and its input framer.
package fft_pkg;
    localparam int FFT_WIDTH = 16;
    localparam int FFT_Q_IN  = 12;
    localparam int FFT_Q_OUT = 11;
    localparam int FFT_N     = 8;

    typedef struct packed {
        logic signed [FFT_WIDTH-1:0] re;
        logic signed [FFT_WIDTH-1:0] im;
    } complex_t;

    typedef enum logic [1:0] {FILL, START, WAIT} framer_state_t;
endpackage

// File: rtl/fft_frame_bank.sv
// fft_frame_bank: N-slot complex register bank, one indexed write per cycle,
// every slot visible in parallel.
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears all slots)
//   we, idx           write enable and slot index
//   wr_real, wr_imag  sample written to slot idx
//   rd_real, rd_imag  all slots, slot k at [k*WIDTH +: WIDTH]
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int WIDTH    = FFT_WIDTH,
    parameter int N_POINTS = FFT_N
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [$clog2(N_POINTS)-1:0] idx,
    input  logic [WIDTH-1:0]            wr_real,
    input  logic [WIDTH-1:0]            wr_imag,
    output logic [N_POINTS*WIDTH-1:0]   rd_real,
    output logic [N_POINTS*WIDTH-1:0]   rd_imag
);
    logic [WIDTH-1:0] re_q [N_POINTS];
    logic [WIDTH-1:0] im_q [N_POINTS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_POINTS; k++) begin
                re_q[k] <= '0;
                im_q[k] <= '0;
            end
        end else if (we) begin
            re_q[idx] <= wr_real;
            im_q[idx] <= wr_imag;
        end
    end

    for (genvar k = 0; k < N_POINTS; k++) begin : g_rd
        assign rd_real[k*WIDTH +: WIDTH] = re_q[k];
        assign rd_imag[k*WIDTH +: WIDTH] = im_q[k];
    end
endmodule

// File: rtl/fft_input_framer.sv
// fft_input_framer: gathers a valid/ready stream of complex Q12 samples into
// N-sample frames, hands each aligned frame to the FFT with a one-cycle start
// and holds it until the FFT reports done; misaligned frames are dropped.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_valid/s_ready          sample handshake (s_ready is register-derived)
//   s_real, s_imag, s_last   sample and end-of-frame marker
//   frame_real, frame_imag   parallel frame, slot k at [k*WIDTH +: WIDTH]
//   fft_start, fft_done      start pulse to / done level from the FFT
//   busy                     a frame is committed to the FFT
//   frame_err                one-cycle pulse per discarded frame
//   frame_cnt                frames started, wrapping
// Build option: FFT_FRAMER_PINGPONG_EN adds a second bank so the next frame
// fills while the FFT works on the current one.
module fft_input_framer
    import fft_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int N_POINTS  = 8,
    parameter int CNT_WIDTH = 16
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [WIDTH-1:0]          s_real,
    input  logic [WIDTH-1:0]          s_imag,
    input  logic                      s_last,
    output logic [N_POINTS*WIDTH-1:0] frame_real,
    output logic [N_POINTS*WIDTH-1:0] frame_imag,
    output logic                      fft_start,
    input  logic                      fft_done,
    output logic                      busy,
    output logic                      frame_err,
    output logic [CNT_WIDTH-1:0]      frame_cnt
);
    localparam int IW = $clog2(N_POINTS);

    framer_state_t state, state_n;
    logic [IW-1:0] idx;
    logic accept, at_end, good, bad, restart;

    assign accept    = s_valid && s_ready;
    assign at_end    = idx == IW'(N_POINTS - 1);
    assign good      = accept && at_end && s_last;
    // s_last early, or missing on the final slot, both break alignment
    assign bad       = accept && (at_end != s_last);
    assign fft_start = state == START;
    assign busy      = state != FILL;

`ifdef FFT_FRAMER_PINGPONG_EN
    // sel names the bank being filled; the FFT always sees the other one
    logic sel, full, full_n, swap;
    logic [N_POINTS*WIDTH-1:0] re0, im0, re1, im1;

    assign full_n     = full || (good && state != FILL);
    assign swap       = (state == FILL && good) || (state == WAIT && fft_done && full_n);
    assign restart    = full_n;
    assign s_ready    = !full;
    assign frame_real = sel ? re0 : re1;
    assign frame_imag = sel ? im0 : im1;

    fft_frame_bank #(.WIDTH(WIDTH), .N_POINTS(N_POINTS)) u_bank0 (
        .clk(clk), .rst(rst), .we(accept && !sel), .idx(idx),
        .wr_real(s_real), .wr_imag(s_imag), .rd_real(re0), .rd_imag(im0)
    );

    fft_frame_bank #(.WIDTH(WIDTH), .N_POINTS(N_POINTS)) u_bank1 (
        .clk(clk), .rst(rst), .we(accept && sel), .idx(idx),
        .wr_real(s_real), .wr_imag(s_imag), .rd_real(re1), .rd_imag(im1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sel  <= 1'b0;
            full <= 1'b0;
        end else begin
            sel  <= sel ^ swap;
            full <= full_n && !swap;
        end
    end
`else
    assign restart = 1'b0;
    assign s_ready = state == FILL;

    fft_frame_bank #(.WIDTH(WIDTH), .N_POINTS(N_POINTS)) u_bank (
        .clk(clk), .rst(rst), .we(accept), .idx(idx),
        .wr_real(s_real), .wr_imag(s_imag), .rd_real(frame_real), .rd_imag(frame_imag)
    );
`endif

    always_comb begin
        state_n = state;
        case (state)
            FILL:    if (good) state_n = START;
            START:   state_n = WAIT;
            WAIT:    if (fft_done) state_n = restart ? START : FILL;
            default: state_n = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            idx       <= '0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_n;
            idx       <= (good || bad) ? '0 : idx + IW'(accept);
            frame_err <= bad;
            frame_cnt <= frame_cnt + CNT_WIDTH'(fft_start);
        end
    end
endmodule

// File: tb/tb_fft_input_framer.sv
// tb_fft_input_framer: self-checking bench for fft_input_framer against a
// frame-level reference model.
module tb_fft_input_framer;
    localparam int W  = 16;
    localparam int N  = 8;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst, s_valid, s_ready, s_last, fft_start, fft_done, busy, frame_err;
    logic [W-1:0] s_real, s_imag;
    logic [N*W-1:0] frame_real, frame_imag;
    logic [CW-1:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fft_input_framer #(.WIDTH(W), .N_POINTS(N), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_real(s_real), .s_imag(s_imag), .s_last(s_last),
        .frame_real(frame_real), .frame_imag(frame_imag),
        .fft_start(fft_start), .fft_done(fft_done), .busy(busy),
        .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    // reference model: samples gathered so far, phase 0 idle / 1 start / 2 waiting
    int m_fill, m_phase;
    logic [CW-1:0] m_cnt;
    logic m_err;
    logic [N*W-1:0] exp_re, exp_im;

    task automatic model_reset();
        m_fill = 0; m_phase = 0; m_cnt = '0; m_err = 1'b0; exp_re = '0; exp_im = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; fft_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic step(input logic v, input logic [W-1:0] re, input logic [W-1:0] im,
                        input logic last, input logic done);
        bit acc;
        s_valid = v; s_real = re; s_imag = im; s_last = last; fft_done = done;
        acc = v && (m_phase == 0);
        @(posedge clk);
        #1;
        m_err = 1'b0;
        if (m_phase == 1) begin
            m_cnt++;
            m_phase = 2;
        end else if (m_phase == 2 && done) begin
            m_phase = 0;
        end
        if (acc) begin
            exp_re[m_fill*W +: W] = re;
            exp_im[m_fill*W +: W] = im;
            if (m_fill == N-1 && last) begin
                m_phase = 1; m_fill = 0;
            end else if (m_fill == N-1 || last) begin
                m_err = 1'b1; m_fill = 0;
            end else begin
                m_fill++;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0 || fft_start !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got ready=%b busy=%b start=%b err=%b exp 1 0 0 0",
                     s_ready, busy, fft_start, frame_err);
        end
        checks++;
        if (frame_cnt !== '0) begin
            errors++;
            $display("FAIL reset_cnt got %0d exp 0", frame_cnt);
        end
        checks++;
        if (frame_real !== '0 || frame_imag !== '0) begin
            errors++;
            $display("FAIL reset_frame got %h/%h exp 0", frame_real, frame_imag);
        end
    endtask

`ifdef FFT_FRAMER_PINGPONG_EN
    task automatic test_pingpong();
        int since;
        logic [N*W-1:0] b_re, b_im, c_re, c_im;
        since = -1;
        for (int k = 0; k < N; k++) begin
            b_re[k*W +: W] = W'(16'h1008 + k);
            b_im[k*W +: W] = W'(-(k + 8));
            c_re[k*W +: W] = W'(16'h3000 + k);
            c_im[k*W +: W] = W'(k);
        end
        for (int c = 0; c < 2*N; c++) begin
            s_valid = 1'b1; s_real = W'(16'h1000 + c); s_imag = W'(-c);
            s_last = (c % N) == N-1; fft_done = since == 3;
            checks++;
            if (s_ready !== 1'b1) begin
                errors++;
                $display("FAIL pp_ready sample %0d got %b exp 1", c, s_ready);
            end
            @(posedge clk);
            #1;
            since = fft_start ? 0 : (since >= 0 ? since + 1 : -1);
        end
        fft_done = 1'b0;
        checks++;
        if (fft_start !== 1'b1 || frame_real !== b_re || frame_imag !== b_im || frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL pp_second_start got start=%b cnt=%0d frame=%h exp 1 1 %h",
                     fft_start, frame_cnt, frame_real, b_re);
        end
        for (int c = 0; c < N; c++) begin
            s_valid = 1'b1; s_real = W'(16'h3000 + c); s_imag = W'(c); s_last = c == N-1;
            checks++;
            if (s_ready !== 1'b1) begin
                errors++;
                $display("FAIL pp_ready_c sample %0d got %b exp 1", c, s_ready);
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (s_ready !== 1'b0 || busy !== 1'b1 || frame_real !== b_re || fft_start !== 1'b0) begin
            errors++;
            $display("FAIL pp_full_hold got ready=%b busy=%b start=%b frame=%h exp 0 1 0 %h",
                     s_ready, busy, fft_start, frame_real, b_re);
        end
        fft_done = 1'b1;
        @(posedge clk);
        #1;
        fft_done = 1'b0;
        checks++;
        if (fft_start !== 1'b1 || frame_real !== c_re || frame_imag !== c_im || frame_cnt !== 16'd2 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL pp_back_to_back got start=%b ready=%b cnt=%0d frame=%h exp 1 1 2 %h",
                     fft_start, s_ready, frame_cnt, frame_real, c_re);
        end
    endtask
`else
    task automatic send_frame();
        for (int k = 0; k < N; k++) step(1'b1, W'($urandom), W'($urandom), k == N-1, 1'b0);
    endtask

    task automatic test_basic();
        for (int k = 0; k < N; k++) begin
            step(1'b1, W'(16'h1000 + k), W'(-k), k == N-1, 1'b0);
            if (k < N-1) begin
                checks++;
                if (fft_start !== 1'b0 || s_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_fill k=%0d got start=%b ready=%b exp 0 1", k, fft_start, s_ready);
                end
            end
        end
        checks++;
        if (fft_start !== 1'b1 || busy !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_start got start=%b busy=%b ready=%b exp 1 1 0", fft_start, busy, s_ready);
        end
        checks++;
        if (frame_real[3*W +: W] !== 16'h1003 || frame_imag[3*W +: W] !== 16'hfffd) begin
            errors++;
            $display("FAIL basic_slot3 got %h/%h exp 1003/fffd", frame_real[3*W +: W], frame_imag[3*W +: W]);
        end
        checks++;
        if (frame_real !== exp_re || frame_imag !== exp_im) begin
            errors++;
            $display("FAIL basic_frame got %h/%h exp %h/%h", frame_real, frame_imag, exp_re, exp_im);
        end
        step(1'b0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (frame_cnt !== 16'd1 || fft_start !== 1'b0) begin
            errors++;
            $display("FAIL basic_cnt got cnt=%0d start=%b exp 1 0", frame_cnt, fft_start);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            checks++;
            if (s_ready !== 1'b0 || fft_start !== 1'b0 || busy !== 1'b1 ||
                frame_real !== exp_re || frame_imag !== exp_im) begin
                errors++;
                $display("FAIL hold cycle %0d got ready=%b start=%b busy=%b frame=%h exp 0 0 1 %h",
                         i, s_ready, fft_start, busy, frame_real, exp_re);
            end
        end
        step(1'b0, '0, '0, 1'b0, 1'b1);
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_release got ready=%b busy=%b exp 1 0", s_ready, busy);
        end
    endtask

    task automatic test_short_frame();
        for (int k = 0; k < 5; k++) step(1'b1, W'($urandom), W'($urandom), k == 4, 1'b0);
        checks++;
        if (frame_err !== 1'b1 || fft_start !== 1'b0) begin
            errors++;
            $display("FAIL short_err got err=%b start=%b exp 1 0", frame_err, fft_start);
        end
        for (int k = 0; k < N; k++) begin
            step(1'b1, W'(16'h2000 + k), W'(k), k == N-1, 1'b0);
            if (k == 0) begin
                checks++;
                if (frame_err !== 1'b0) begin
                    errors++;
                    $display("FAIL short_err_pulse got %b exp 0", frame_err);
                end
            end
        end
        checks++;
        if (fft_start !== 1'b1 || frame_real !== exp_re || frame_imag !== exp_im) begin
            errors++;
            $display("FAIL short_recover got start=%b frame=%h exp 1 %h", fft_start, frame_real, exp_re);
        end
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_long_frame();
        for (int k = 0; k < N; k++) step(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0);
        checks++;
        if (frame_err !== 1'b1 || fft_start !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL long_err got err=%b start=%b ready=%b exp 1 0 1", frame_err, fft_start, s_ready);
        end
        for (int k = 0; k < N; k++) step(1'b1, W'(16'h4000 + k), W'(16'h8000 + k), k == N-1, 1'b0);
        checks++;
        if (fft_start !== 1'b1 || frame_err !== 1'b0 || frame_real !== exp_re || frame_imag !== exp_im) begin
            errors++;
            $display("FAIL long_recover got start=%b err=%b frame=%h exp 1 0 %h",
                     fft_start, frame_err, frame_real, exp_re);
        end
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic v, last, done;
        logic [3:0] st, exp_st;
        for (int i = 0; i < 600; i++) begin
            v = $urandom_range(0, 3) != 0;
            last = (m_fill == N-1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
            done = $urandom_range(0, 3) == 0;
            step(v, W'($urandom), W'($urandom), last, done);
            st = {s_ready, fft_start, busy, frame_err};
            exp_st = {m_phase == 0, m_phase == 1, m_phase != 0, m_err};
            checks++;
            if (st !== exp_st || frame_cnt !== m_cnt) begin
                errors++;
                $display("FAIL random_ctrl cycle %0d got rdy/start/busy/err=%b cnt=%0d exp %b cnt=%0d",
                         i, st, frame_cnt, exp_st, m_cnt);
            end
            checks++;
            if (frame_real !== exp_re || frame_imag !== exp_im) begin
                errors++;
                $display("FAIL random_frame cycle %0d got %h/%h exp %h/%h",
                         i, frame_real, frame_imag, exp_re, exp_im);
            end
        end
    endtask

    task automatic test_reset_wait();
        apply_reset();
        send_frame();
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        send_frame();
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (frame_cnt !== 16'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rstwait_pre got cnt=%0d busy=%b exp 2 1", frame_cnt, busy);
        end
        rst = 1'b1; s_valid = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0 || fft_start !== 1'b0 || frame_cnt !== '0) begin
            errors++;
            $display("FAIL rstwait_ctrl got ready=%b busy=%b start=%b cnt=%0d exp 1 0 0 0",
                     s_ready, busy, fft_start, frame_cnt);
        end
        checks++;
        if (frame_real !== '0 || frame_imag !== '0) begin
            errors++;
            $display("FAIL rstwait_frame got %h/%h exp 0", frame_real, frame_imag);
        end
        rst = 1'b0; s_valid = 1'b0;
        model_reset();
    endtask
`endif

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_real = '0; s_imag = '0; s_last = 1'b0; fft_done = 1'b0;
        test_reset();
`ifdef FFT_FRAMER_PINGPONG_EN
        test_pingpong();
`else
        test_basic();
        test_hold();
        test_short_frame();
        test_long_frame();
        test_random();
        test_reset_wait();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
